// File: rtl/wb_pkg.sv
// Shared definitions for the register writeback block: register index width,
// default queue depth and the queued entry layout.
package wb_pkg;

  // Width of a destination register index.
  localparam int REG_IDX_W = 4;

  // Default number of pending-write queue entries.
  localparam int WB_DEPTH_DEFAULT = 4;

  // Default data word width.
  localparam int WB_DATA_W_DEFAULT = 32;

  // One pending register write: destination index plus value.
  typedef struct packed {
    logic [REG_IDX_W-1:0]         reg_idx;
    logic [WB_DATA_W_DEFAULT-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Pending-write queue for reg_writeback: circular storage with head/tail
// pointers and an occupancy count. Two write ports allow two entries to be
// appended on one edge (port 0 lands first, so it is the older one) and one
// read port pops the head. Port 1 is only honoured together with port 0.
// The caller guarantees it never overfills the queue and never pops it empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter type entry_t = wb_entry_t,
  parameter int  DEPTH   = WB_DEPTH_DEFAULT,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push0_en,
  input  entry_t           push0_entry,
  input  logic             push1_en,
  input  entry_t           push1_entry,
  input  logic             pop_en,
  output entry_t           head_entry,
  output entry_t           entries [DEPTH],
  output logic [PTR_W-1:0] head_ptr,
  output logic [CNT_W-1:0] count
);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] head_d;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W-1:0] tail_d;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [1:0]       n_push;

  // Number of entries appended this edge (port 1 only counts alongside port 0).
  always_comb begin
    n_push = 2'd0;
    if (push0_en) begin
      n_push = (push1_en) ? 2'd2 : 2'd1;
    end
  end

  // Next storage contents, pointer positions and occupancy; pointers wrap
  // naturally because DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push0_en) begin
      mem_d[tail_q] = push0_entry;
      tail_d        = tail_q + PTR_W'(1);
      if (push1_en) begin
        mem_d[tail_q + PTR_W'(1)] = push1_entry;
        tail_d                    = tail_q + PTR_W'(2);
      end
    end
    if (pop_en) begin
      head_d = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(n_push) - CNT_W'(pop_en);
  end

  // Entry storage needs no reset: only slots inside the count are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Pointers and count return to empty on reset, discarding pending entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_entry = mem_q[head_q];
  assign entries    = mem_q;
  assign head_ptr   = head_q;
  assign count      = count_q;

endmodule

// File: rtl/reg_writeback.sv
// Register writeback stage: accepts ALU and load results into a small FIFO,
// drains one entry per cycle through a registered register-file write port,
// and optionally offers a forwarding lookup over all not-yet-retired writes.
// Optional feature macro: WB_FORWARD_EN (forwarding compare logic). Without
// it fwd_hit/fwd_data are tied to zero and fwd_reg is ignored.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int  DATA_W = WB_DATA_W_DEFAULT,
  parameter int  DEPTH  = WB_DEPTH_DEFAULT,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_reg,
  input  logic [DATA_W-1:0]    alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [REG_IDX_W-1:0] mem_reg,
  input  logic [DATA_W-1:0]    mem_data,
  output logic                 mem_ready,
  output logic                 wr_en,
  output logic [REG_IDX_W-1:0] wr_reg,
  output logic [DATA_W-1:0]    wr_data,
  input  logic [REG_IDX_W-1:0] fwd_reg,
  output logic                 fwd_hit,
  output logic [DATA_W-1:0]    fwd_data,
  output logic [CNT_W-1:0]     count
);

  typedef struct packed {
    logic [REG_IDX_W-1:0] reg_idx;
    logic [DATA_W-1:0]    data;
  } q_entry_t;

  q_entry_t             alu_entry;
  q_entry_t             mem_entry;
  q_entry_t             push0_entry;
  q_entry_t             head_entry;
  q_entry_t             queue_entries [DEPTH];
  logic [PTR_W-1:0]     head_ptr;
  logic [CNT_W-1:0]     q_count;
  logic                 alu_acc;
  logic                 mem_acc;
  logic                 push0_en;
  logic                 push1_en;
  logic                 pop_en;

  logic                 wr_en_q;
  logic                 wr_en_d;
  logic [REG_IDX_W-1:0] wr_reg_q;
  logic [REG_IDX_W-1:0] wr_reg_d;
  logic [DATA_W-1:0]    wr_data_q;
  logic [DATA_W-1:0]    wr_data_d;

  assign alu_entry = '{reg_idx: alu_reg, data: alu_data};
  assign mem_entry = '{reg_idx: mem_reg, data: mem_data};

  // Readiness depends only on occupancy and the valids; a pop on the same
  // edge gives no credit. With one slot left the load takes it.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (!rst) begin
      if (q_count == CNT_W'(DEPTH)) begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
      end else if (q_count == CNT_W'(DEPTH - 1)) begin
        mem_ready = 1'b1;
        alu_ready = !mem_valid;
      end else begin
        mem_ready = 1'b1;
        alu_ready = 1'b1;
      end
    end
  end

  assign alu_acc = alu_valid & alu_ready;
  assign mem_acc = mem_valid & mem_ready;

  // Compact accepted offers onto the FIFO ports, load first so it is older.
  always_comb begin
    push0_en    = mem_acc | alu_acc;
    push0_entry = mem_acc ? mem_entry : alu_entry;
    push1_en    = mem_acc & alu_acc;
  end

  // The head is retired whenever the queue holds anything.
  assign pop_en = (q_count != '0);

  wb_fifo #(
    .entry_t (q_entry_t),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push0_en    (push0_en),
    .push0_entry (push0_entry),
    .push1_en    (push1_en),
    .push1_entry (alu_entry),
    .pop_en      (pop_en),
    .head_entry  (head_entry),
    .entries     (queue_entries),
    .head_ptr    (head_ptr),
    .count       (q_count)
  );

  // Output stage loads the popped head; index and data hold when idle.
  always_comb begin
    wr_en_d   = pop_en;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    if (pop_en) begin
      wr_reg_d  = head_entry.reg_idx;
      wr_data_d = head_entry.data;
    end
  end

  // Registered write port, cleared by reset so a mid-drain reset emits nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q   <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_reg  = wr_reg_q;
  assign wr_data = wr_data_q;
  assign count   = q_count;

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Search oldest to youngest (output stage, then queue head to tail) so the
  // last match found is the youngest pending value for that register.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    if (!rst) begin
      if (wr_en_q && (wr_reg_q == fwd_reg)) begin
        fwd_hit  = 1'b1;
        fwd_data = wr_data_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = head_ptr + PTR_W'(i);
        if ((i < int'(q_count)) && (queue_entries[fwd_idx].reg_idx == fwd_reg)) begin
          fwd_hit  = 1'b1;
          fwd_data = queue_entries[fwd_idx].data;
        end
      end
    end
  end
`else
  logic unused_fwd_bits;

  // No forwarding compare: outputs tied low; lookup inputs folded into a
  // deliberately unused signal.
  always_comb begin
    unused_fwd_bits = ^fwd_reg ^ ^head_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      unused_fwd_bits = unused_fwd_bits ^ ^queue_entries[i];
    end
  end

  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed testbench for reg_writeback (DEPTH=4, DATA_W=32).
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  alu_reg;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_reg;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        wr_en;
  logic [3:0]  wr_reg;
  logic [31:0] wr_data;
  logic [3:0]  fwd_reg;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;

  int n_asserts;
  int n_failures;

`ifdef WB_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  reg_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_reg   (alu_reg),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_reg   (mem_reg),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .fwd_reg   (fwd_reg),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic av, input logic [3:0] ar, input logic [31:0] ad,
                               input logic mv, input logic [3:0] mr, input logic [31:0] md);
    alu_valid = av;
    alu_reg   = ar;
    alu_data  = ad;
    mem_valid = mv;
    mem_reg   = mr;
    mem_data  = md;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic en, input logic [3:0] r,
                            input logic [31:0] d);
    checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'(en));
    checkOutput({tag, "_wr_reg"}, 32'(wr_reg), 32'(r));
    checkOutput({tag, "_wr_data"}, wr_data, d);
  endtask

  initial begin
    n_asserts  = 0;
    n_failures = 0;
    $display("[TB] start, forwarding %0d", FWD);

    // Reset with offers present: nothing ready, nothing accepted.
    rst     = 1'b1;
    fwd_reg = 4'd3;
    applyStimulus(1'b1, 4'd3, 32'hAA, 1'b1, 4'd5, 32'h11);
    #1;
    checkOutput("rst_alu_ready", 32'(alu_ready), 32'd0);
    checkOutput("rst_mem_ready", 32'(mem_ready), 32'd0);
    checkOutput("rst_fwd_hit", 32'(fwd_hit), 32'd0);
    tick();
    tick();
    checkWrite("rst", 1'b0, 4'd0, 32'h0);
    checkOutput("rst_count", 32'(count), 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    #1;
    checkOutput("post_rst_count", 32'(count), 32'd0);

    // Single ALU offer: accepted, written one cycle later, then idle holds.
    applyStimulus(1'b1, 4'd3, 32'h0000_00AA, 1'b0, 4'd0, 32'h0);
    #1;
    checkOutput("t1_alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("t1_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checkOutput("t1_count_acc", 32'(count), 32'd1);
    checkOutput("t1_wr_en_early", 32'(wr_en), 32'd0);
    tick();
    checkWrite("t1_emit", 1'b1, 4'd3, 32'hAA);
    checkOutput("t1_count_drained", 32'(count), 32'd0);
    tick();
    checkWrite("t1_hold", 1'b0, 4'd3, 32'hAA);

    // Both valid into empty queue: load older, emitted first.
    applyStimulus(1'b1, 4'd6, 32'h22, 1'b1, 4'd5, 32'h11);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checkOutput("t2_count", 32'(count), 32'd2);
    tick();
    checkWrite("t2_first", 1'b1, 4'd5, 32'h11);
    checkOutput("t2_count1", 32'(count), 32'd1);
    tick();
    checkWrite("t2_second", 1'b1, 4'd6, 32'h22);
    tick();
    checkOutput("t2_idle", 32'(wr_en), 32'd0);

    // Fill to DEPTH-1: load wins the last slot, ALU refused only when load valid.
    applyStimulus(1'b1, 4'd2, 32'h102, 1'b1, 4'd1, 32'h101);
    tick();
    checkOutput("t3_count2", 32'(count), 32'd2);
    applyStimulus(1'b1, 4'd4, 32'h104, 1'b1, 4'd3, 32'h103);
    #1;
    checkOutput("t3_c2_alu_ready", 32'(alu_ready), 32'd1);
    checkOutput("t3_c2_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    checkOutput("t3_count3", 32'(count), 32'd3);
    checkWrite("t3_w101", 1'b1, 4'd1, 32'h101);
    applyStimulus(1'b1, 4'd8, 32'h108, 1'b0, 4'd0, 32'h0);
    #1;
    checkOutput("t3_c3_alu_only_ready", 32'(alu_ready), 32'd1);
    applyStimulus(1'b1, 4'd8, 32'h108, 1'b1, 4'd7, 32'h107);
    #1;
    checkOutput("t3_c3_alu_ready", 32'(alu_ready), 32'd0);
    checkOutput("t3_c3_mem_ready", 32'(mem_ready), 32'd1);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checkOutput("t3_count_hold", 32'(count), 32'd3);
    checkWrite("t3_w102", 1'b1, 4'd2, 32'h102);
    tick();
    checkWrite("t3_w103", 1'b1, 4'd3, 32'h103);
    tick();
    checkWrite("t3_w104", 1'b1, 4'd4, 32'h104);
    tick();
    checkWrite("t3_w107", 1'b1, 4'd7, 32'h107);
    checkOutput("t3_count0", 32'(count), 32'd0);
    tick();
    checkWrite("t3_no_alu", 1'b0, 4'd7, 32'h107);

    // Forwarding: youngest pending value wins, same-cycle offers not searched.
    fwd_reg = 4'd9;
    applyStimulus(1'b1, 4'd9, 32'h2, 1'b1, 4'd9, 32'h1);
    #1;
    checkOutput("t4_offer_not_searched", 32'(fwd_hit), 32'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checkOutput("t4_q_hit", 32'(fwd_hit), FWD ? 32'd1 : 32'd0);
    checkOutput("t4_q_data", fwd_data, FWD ? 32'h2 : 32'h0);
    fwd_reg = 4'd10;
    #1;
    checkOutput("t4_miss_hit", 32'(fwd_hit), 32'd0);
    checkOutput("t4_miss_data", fwd_data, 32'h0);
    fwd_reg = 4'd9;
    tick();
    checkOutput("t4_mix_hit", 32'(fwd_hit), FWD ? 32'd1 : 32'd0);
    checkOutput("t4_mix_data", fwd_data, FWD ? 32'h2 : 32'h0);
    checkWrite("t4_w1", 1'b1, 4'd9, 32'h1);
    tick();
    checkOutput("t4_out_hit", 32'(fwd_hit), FWD ? 32'd1 : 32'd0);
    checkOutput("t4_out_data", fwd_data, FWD ? 32'h2 : 32'h0);
    checkWrite("t4_w2", 1'b1, 4'd9, 32'h2);
    tick();
    checkOutput("t4_idle_hit", 32'(fwd_hit), 32'd0);
    checkOutput("t4_idle_data", fwd_data, 32'h0);

    // Reset during drain drops remaining entries with no further writes.
    applyStimulus(1'b1, 4'd2, 32'hA2, 1'b1, 4'd1, 32'hA1);
    tick();
    applyStimulus(1'b1, 4'd3, 32'hA3, 1'b0, 4'd0, 32'h0);
    tick();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    checkOutput("t5_count_pre", 32'(count), 32'd2);
    checkWrite("t5_wA1", 1'b1, 4'd1, 32'hA1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkWrite("t5_after_rst", 1'b0, 4'd0, 32'h0);
    checkOutput("t5_count_rst", 32'(count), 32'd0);
    tick();
    checkOutput("t5_no_write1", 32'(wr_en), 32'd0);
    tick();
    checkOutput("t5_no_write2", 32'(wr_en), 32'd0);
    checkOutput("t5_count_end", 32'(count), 32'd0);

    // Ten back-to-back single offers: pointers wrap, order preserved.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 4'(i), 32'h200 + 32'(i), 1'b0, 4'd0, 32'h0);
      tick();
      checkOutput($sformatf("t6_count_%0d", i), 32'(count), 32'd1);
      if (i > 0) begin
        checkWrite($sformatf("t6_w%0d", i - 1), 1'b1, 4'(i - 1), 32'h200 + 32'(i - 1));
      end
    end
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0, 32'h0);
    tick();
    checkWrite("t6_w9", 1'b1, 4'd9, 32'h209);
    checkOutput("t6_count_end", 32'(count), 32'd0);
    tick();
    checkOutput("t6_idle", 32'(wr_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
    $finish;
  end

endmodule
